// File: rtl/nes_mem_arbiter_if.sv
// Host command port of the NES memory arbiter: single-beat command handshake
// with a registered read-data return path.
interface nes_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              valid;
  logic [7:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, op, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, op, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/nes_mem_arbiter.sv
// Sequencer/arbiter for the NES shared memory: owns CPU reset/run/pause and
// lends the single memory port to host read/write accesses while stalling the CPU.
module nes_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RESET_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  nes_mem_arbiter_if.slave  host,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_ready,
  output logic              cpu_reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        status
);

  localparam int               CNT_W     = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_HOLD - 1);

  localparam logic [7:0] OP_RESET = 8'd0;
  localparam logic [7:0] OP_START = 8'd1;
  localparam logic [7:0] OP_PAUSE = 8'd2;
  localparam logic [7:0] OP_WRITE = 8'd3;
  localparam logic [7:0] OP_READ  = 8'd4;

  typedef enum logic [2:0] {
    RST    = 3'd0,
    HALT   = 3'd1,
    RESUME = 3'd2,
    RUN    = 3'd3,
    HWR    = 3'd4,
    HRD    = 3'd5,
    HRD2   = 3'd6
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  hold_cnt;
  logic              run_flag;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              host_ready_q, cpu_ready_q, cpu_reset_q, rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;

  assign accept = host.valid & host_ready_q;

  always_comb begin
    state_next = state;
    case (state)
      RST:  if (hold_cnt == '0) state_next = HALT;
      HALT, RUN: begin
        if (accept) begin
          case (host.op)
            OP_RESET: state_next = RST;
            OP_START: if (state == HALT) state_next = RESUME;
            OP_PAUSE: state_next = HALT;
            OP_WRITE: state_next = HWR;
            OP_READ:  state_next = HRD;
            default:  state_next = state;
          endcase
        end
      end
      RESUME:    state_next = RUN;
      HWR, HRD2: state_next = run_flag ? RESUME : HALT;
      HRD:       state_next = HRD2;
      default:   state_next = RST;
    endcase
  end

  // Handshake/enable outputs are registered from the next state so they line up with status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RST;
      hold_cnt     <= HOLD_LOAD;
      run_flag     <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      host_ready_q <= 1'b0;
      cpu_ready_q  <= 1'b0;
      cpu_reset_q  <= 1'b1;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state        <= state_next;
      host_ready_q <= (state_next == HALT) || (state_next == RUN);
      cpu_ready_q  <= (state_next == RUN);
      cpu_reset_q  <= (state_next == RST);
      rvalid_q     <= 1'b0;
      if (state == RST) hold_cnt <= hold_cnt - CNT_W'(1);
      if (state != RST && state_next == RST) hold_cnt <= HOLD_LOAD;
      if (accept) begin
        case (host.op)
          OP_RESET, OP_PAUSE: run_flag <= 1'b0;
          OP_START:           run_flag <= 1'b1;
          OP_WRITE: begin
            lat_addr  <= host.addr;
            lat_wdata <= host.wdata;
          end
          OP_READ:            lat_addr <= host.addr;
          default:            ;
        endcase
      end
      if (state == HRD2) begin
        rdata_q  <= mem_rdata;
        rvalid_q <= 1'b1;
      end
    end
  end

  // RESUME re-presents the stalled CPU address so cpu_din is fresh on the first RUN cycle.
  always_comb begin
    mem_addr  = '0;
    mem_write = 1'b0;
    mem_wdata = '0;
    case (state)
      RUN: begin
        mem_addr  = cpu_addr;
        mem_write = cpu_write;
        mem_wdata = cpu_dout;
      end
      RESUME:    mem_addr = cpu_addr;
      HWR: begin
        mem_addr  = lat_addr;
        mem_write = 1'b1;
        mem_wdata = lat_wdata;
      end
      HRD, HRD2: mem_addr = lat_addr;
      default:   ;
    endcase
  end

  assign cpu_din     = mem_rdata;
  assign cpu_ready   = cpu_ready_q;
  assign cpu_reset   = cpu_reset_q;
  assign host.ready  = host_ready_q;
  assign host.rvalid = rvalid_q;
  assign host.rdata  = rdata_q;
  assign status      = state;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Randomized self-checking bench for nes_mem_arbiter: a toy CPU, a synchronous
// memory and a command-level reference model of expected per-cycle behaviour.
module tb_nes_mem_arbiter;
  localparam int ADDR_W = 16, DATA_W = 8, RESET_HOLD = 4;
  localparam logic [7:0] OP_RESET = 8'd0, OP_START = 8'd1, OP_PAUSE = 8'd2,
                         OP_WRITE = 8'd3, OP_READ = 8'd4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_dout, cpu_din;
  logic              cpu_ready, cpu_reset;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [2:0]        status;

  logic [DATA_W-1:0] mem     [0:65535];
  logic [DATA_W-1:0] ref_mem [0:65535];
  logic [ADDR_W-1:0] wr_addrs[$];
  bit                model_run;
  bit                cpu_adv;
  int                n_checks = 0, n_pass = 0;

  nes_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host ();

  nes_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_HOLD(RESET_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .host(host),
    .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_ready(cpu_ready), .cpu_reset(cpu_reset),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .status(status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One clock; the toy CPU commits its write and advances only after cycles it was enabled.
  task automatic tick();
    @(negedge clk);
    cpu_adv = cpu_ready;
    if (reset_n && cpu_ready && cpu_write) ref_mem[cpu_addr] = cpu_dout;
    @(posedge clk);
    #1;
    if (cpu_adv) begin
      cpu_addr  = 16'h4000 + 16'($urandom_range(0, 15));
      cpu_write = ($urandom_range(0, 3) == 0);
      cpu_dout  = 8'($urandom);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] wdata);
    int waited = 0;
    host.valid = 1'b1;
    host.op    = op;
    host.addr  = addr;
    host.wdata = wdata;
    while (!host.ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!host.ready) begin
      checkOutput("accept_timeout", host.ready, 1'b1);
      host.valid = 1'b0;
      return;
    end
    tick();
    host.valid = 1'b0;
  endtask

  task automatic expectResetSequence();
    for (int i = 0; i < RESET_HOLD; i++) begin
      checkOutput("reset_hold", {cpu_reset, cpu_ready, host.ready, status}, {1'b1, 1'b0, 1'b0, 3'd0});
      tick();
    end
    checkOutput("halt_after_reset", {cpu_reset, cpu_ready, host.ready, status}, {1'b0, 1'b0, 1'b1, 3'd1});
  endtask

  // Expected behaviour from cycle N+1 onward, written per command from the timing rules.
  task automatic expectAfter(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] wdata);
    logic [15:0] held;
    held = cpu_addr;
    case (op)
      OP_RESET: begin
        model_run = 1'b0;
        expectResetSequence();
      end
      OP_START: begin
        if (!model_run) begin
          checkOutput("resume", {status, cpu_ready, mem_write, mem_addr}, {3'd2, 1'b0, 1'b0, held});
          tick();
          checkOutput("run_after_start", {status, cpu_ready, host.ready, mem_addr}, {3'd3, 1'b1, 1'b1, held});
          checkOutput("cpu_din_start", cpu_din, ref_mem[held]);
          model_run = 1'b1;
        end else begin
          checkOutput("start_in_run", {status, cpu_ready, host.ready}, {3'd3, 1'b1, 1'b1});
        end
      end
      OP_PAUSE: begin
        model_run = 1'b0;
        checkOutput("pause", {status, cpu_ready, host.ready, mem_write}, {3'd1, 1'b0, 1'b1, 1'b0});
      end
      OP_WRITE: begin
        checkOutput("hwr_bus", {mem_write, mem_addr, mem_wdata}, {1'b1, addr, wdata});
        checkOutput("hwr_ctrl", {status, cpu_ready, host.ready}, {3'd4, 1'b0, 1'b0});
        tick();
        if (model_run) begin
          checkOutput("resume_after_write", {status, cpu_ready, host.ready, mem_write, mem_addr},
                      {3'd2, 1'b0, 1'b0, 1'b0, held});
          tick();
          checkOutput("run_after_write", {status, cpu_ready, host.ready, mem_addr}, {3'd3, 1'b1, 1'b1, held});
          checkOutput("cpu_din_fresh", cpu_din, ref_mem[held]);
        end else begin
          checkOutput("halt_after_write", {status, cpu_ready, host.ready, mem_write}, {3'd1, 1'b0, 1'b1, 1'b0});
        end
      end
      OP_READ: begin
        checkOutput("hrd", {status, cpu_ready, host.ready, host.rvalid, mem_write, mem_addr},
                    {3'd5, 1'b0, 1'b0, 1'b0, 1'b0, addr});
        tick();
        checkOutput("hrd2", {status, host.rvalid, mem_write, mem_addr}, {3'd6, 1'b0, 1'b0, addr});
        tick();
        checkOutput("rvalid_data", {host.rvalid, host.rdata}, {1'b1, ref_mem[addr]});
        checkOutput("post_read_state", {status, cpu_ready}, {(model_run ? 3'd2 : 3'd1), 1'b0});
        tick();
        checkOutput("rvalid_pulse", {host.rvalid, host.rdata, status},
                    {1'b0, ref_mem[addr], (model_run ? 3'd3 : 3'd1)});
      end
      default: begin
        checkOutput("noop", {status, cpu_ready, host.ready}, {(model_run ? 3'd3 : 3'd1), model_run, 1'b1});
      end
    endcase
  endtask

  task automatic doCommand(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] wdata);
    applyStimulus(op, addr, wdata);
    if (op == OP_WRITE) begin
      ref_mem[addr] = wdata;
      wr_addrs.push_back(addr);
    end
    expectAfter(op, addr, wdata);
  endtask

  function automatic logic [15:0] randHostAddr();
    if ($urandom_range(0, 1) == 1) return 16'h4000 + 16'($urandom_range(0, 15));
    return 16'($urandom_range(0, 255));
  endfunction

  initial begin
    logic [7:0]  op;
    logic [15:0] a;
    int          r;
    host.valid = 1'b0; host.op = '0; host.addr = '0; host.wdata = '0;
    cpu_addr = 16'h4000; cpu_write = 1'b0; cpu_dout = '0;
    model_run = 1'b0; cpu_adv = 1'b0;

    repeat (3) tick();
    checkOutput("reset_ctrl", {cpu_reset, status, cpu_ready, host.ready, host.rvalid, mem_write},
                {1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    checkOutput("reset_bus", {mem_addr, mem_wdata, host.rdata}, 32'd0);
    reset_n = 1'b1;
    expectResetSequence();

    // Give every address the toy CPU can touch a known value.
    for (int i = 0; i < 16; i++) doCommand(OP_WRITE, 16'h4000 + 16'(i), 8'($urandom));

    doCommand(OP_WRITE, 16'hFFFC, 8'h5A);
    doCommand(OP_READ, 16'hFFFC, 8'h00);
    checkOutput("read_fffc", host.rdata, 8'h5A);

    // A command held valid while the previous access is in flight.
    applyStimulus(OP_WRITE, 16'h0010, 8'h33);
    ref_mem[16'h0010] = 8'h33;
    wr_addrs.push_back(16'h0010);
    doCommand(OP_READ, 16'h0010, 8'h00);

    doCommand(OP_START, 16'h0, 8'h0);
    repeat (5) tick();
    doCommand(OP_WRITE, 16'h0200, 8'h11);
    repeat (3) tick();
    doCommand(OP_PAUSE, 16'h0, 8'h0);
    doCommand(OP_START, 16'h0, 8'h0);
    doCommand(8'h07, 16'h0, 8'h0);
    doCommand(OP_START, 16'h0, 8'h0);
    doCommand(OP_RESET, 16'h0, 8'h0);

    // Reset asserted while a read owns the memory.
    doCommand(OP_START, 16'h0, 8'h0);
    applyStimulus(OP_READ, 16'hFFFC, 8'h00);
    checkOutput("mid_read_state", status, 3'd5);
    #2 reset_n = 1'b0;
    #1 checkOutput("async_reset", {status, cpu_reset, host.ready, cpu_ready, mem_write, host.rvalid},
                   {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("no_rvalid_in_reset", {host.rvalid, host.rdata, mem_write}, 32'd0);
    end
    reset_n = 1'b1;
    model_run = 1'b0;
    expectResetSequence();
    doCommand(OP_WRITE, 16'h0020, 8'hC3);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5)       op = OP_RESET;
      else if (r < 20) op = OP_START;
      else if (r < 30) op = OP_PAUSE;
      else if (r < 60) op = OP_WRITE;
      else if (r < 90) op = OP_READ;
      else             op = 8'($urandom_range(5, 255));
      a = (op == OP_READ) ? wr_addrs[$urandom_range(0, wr_addrs.size() - 1)] : randHostAddr();
      doCommand(op, a, 8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
